// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU: grants one operation,
// drives the ALU for a single cycle, then holds the response until it is taken.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [15:0] alu_tmp1,
  output logic [15:0] alu_tmp2,
  output logic [2:0]  alu_op,
  output logic        alu_enable,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_sign,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_data,
  output logic        resp_zero,
  output logic        resp_carry,
  output logic        resp_sign,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic        prio;
  logic        winner;
  logic        accept;
  logic        req_err;
  logic [15:0] win_a;
  logic [15:0] win_b;
  logic [2:0]  win_op;

  // Round-robin pick; reset gates accept so nothing is granted while reset is high.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = prio;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
    accept  = (state == IDLE) && !reset && (req0_valid || req1_valid);
    win_a   = winner ? req1_a  : req0_a;
    win_b   = winner ? req1_b  : req0_b;
    win_op  = winner ? req1_op : req0_op;
    req_err = (win_op > 3'd4) ||
              (((win_op == 3'd3) || (win_op == 3'd4)) && (win_b == 16'd0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Illegal ops and divide-by-zero skip the ALU and go straight to the response.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = req_err ? RESP : EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !winner;
    req1_ready = accept && winner;
    alu_enable = (state == EXEC);
    resp_valid = (state == RESP);
  end

  // Operand registers only move on accept, so the ALU sees stable inputs in EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio       <= 1'b0;
      alu_tmp1   <= 16'd0;
      alu_tmp2   <= 16'd0;
      alu_op     <= 3'd0;
      resp_id    <= 1'b0;
      resp_data  <= 16'd0;
      resp_zero  <= 1'b0;
      resp_carry <= 1'b0;
      resp_sign  <= 1'b0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      alu_tmp1 <= win_a;
      alu_tmp2 <= win_b;
      alu_op   <= win_op;
      resp_id  <= winner;
      prio     <= !winner;
      if (req_err) begin
        resp_data  <= 16'd0;
        resp_zero  <= 1'b0;
        resp_carry <= 1'b0;
        resp_sign  <= 1'b0;
        resp_err   <= 1'b1;
      end
    end else if (state == EXEC) begin
      resp_data  <= alu_result;
      resp_zero  <= alu_zero;
      resp_carry <= alu_carry;
      resp_sign  <= alu_sign;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model standing in for the shared ALU.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic [15:0] alu_tmp1, alu_tmp2;
  logic [2:0]  alu_op;
  logic        alu_enable;
  logic [15:0] alu_result;
  logic        alu_zero, alu_carry, alu_sign;
  logic        resp_valid, resp_ready, resp_id;
  logic [15:0] resp_data;
  logic        resp_zero, resp_carry, resp_sign, resp_err;

  int checkCount;
  int failCount;
  int enableCount;
  logic respSeen;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .alu_tmp1(alu_tmp1), .alu_tmp2(alu_tmp2), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_carry(resp_carry),
    .resp_sign(resp_sign), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model: purely combinational on the registered operands.
  logic signed [15:0] sa, sb;
  logic signed [31:0] prod;
  logic [16:0] wide;
  always_comb begin
    sa   = alu_tmp1;
    sb   = alu_tmp2;
    prod = sa * sb;
    wide = 17'd0;
    case (alu_op)
      3'd0: wide = {1'b0, alu_tmp1} + {1'b0, alu_tmp2};
      3'd1: wide = {1'b0, alu_tmp1} - {1'b0, alu_tmp2};
      3'd2: wide = {1'b0, prod[15:0]};
      3'd3: if (sb != 0) wide = {1'b0, sa / sb};
      3'd4: if (sb != 0) wide = {1'b0, sa % sb};
      default: wide = 17'd0;
    endcase
    alu_result = wide[15:0];
    alu_carry  = (alu_op == 3'd0 || alu_op == 3'd1) ? wide[16] : 1'b0;
    alu_zero   = (wide[15:0] == 16'd0);
    alu_sign   = wide[15];
  end

  always @(posedge clk) begin
    if (alu_enable) enableCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                               input logic [2:0] op0, input logic v1, input logic [15:0] a1,
                               input logic [15:0] b1, input logic [2:0] op1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    checkCount  = 0;
    failCount   = 0;
    enableCount = 0;
    resp_ready  = 1'b1;
    reset       = 1'b1;
    applyStimulus(1, 16'd1, 16'd1, 3'd0, 1, 16'd2, 16'd2, 3'd0);
    stepCycle();
    stepCycle();

    // Reset state, with both requesters asking
    checkOutput("rst_ready0", req0_ready, 0);
    checkOutput("rst_ready1", req1_ready, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_alu_enable", alu_enable, 0);
    checkOutput("rst_tmp1", alu_tmp1, 0);
    checkOutput("rst_resp_data", resp_data, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;

    // Single add from req0
    enableCount = 0;
    applyStimulus(1, 16'd5, 16'd7, 3'd0, 0, 0, 0, 0);
    checkOutput("add_ready0", req0_ready, 1);
    checkOutput("add_ready1", req1_ready, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("add_exec_enable", alu_enable, 1);
    checkOutput("add_exec_valid", resp_valid, 0);
    checkOutput("add_tmp1", alu_tmp1, 5);
    checkOutput("add_tmp2", alu_tmp2, 7);
    stepCycle();
    checkOutput("add_resp_valid", resp_valid, 1);
    checkOutput("add_resp_id", resp_id, 0);
    checkOutput("add_resp_data", resp_data, 12);
    checkOutput("add_resp_err", resp_err, 0);
    checkOutput("add_resp_enable", alu_enable, 0);
    stepCycle();
    checkOutput("add_idle_valid", resp_valid, 0);
    checkOutput("add_enable_count", enableCount, 1);

    // Contention straight out of reset: grants alternate starting with req0
    applyStimulus(1, 16'd1, 16'd2, 3'd0, 1, 16'd10, 16'd20, 3'd1);
    doReset();
    for (int i = 0; i < 4; i++) begin
      logic expId;
      expId = i[0];
      for (int k = 0; k < 10 && !(req0_ready || req1_ready); k++) stepCycle();
      checkOutput($sformatf("cont%0d_ready0", i), req0_ready, !expId);
      checkOutput($sformatf("cont%0d_ready1", i), req1_ready, expId);
      stepCycle();
      checkOutput($sformatf("cont%0d_pulse", i), req0_ready | req1_ready, 0);
      stepCycle();
      checkOutput($sformatf("cont%0d_valid", i), resp_valid, 1);
      checkOutput($sformatf("cont%0d_id", i), resp_id, expId);
      checkOutput($sformatf("cont%0d_data", i), resp_data, expId ? 16'hFFF6 : 16'd3);
      checkOutput($sformatf("cont%0d_sign", i), resp_sign, expId);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();

    // Divide by zero from req1 bypasses the ALU
    enableCount = 0;
    applyStimulus(0, 0, 0, 0, 1, 16'd9, 16'd0, 3'd3);
    checkOutput("dz_ready1", req1_ready, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("dz_valid", resp_valid, 1);
    checkOutput("dz_err", resp_err, 1);
    checkOutput("dz_data", resp_data, 0);
    checkOutput("dz_id", resp_id, 1);
    stepCycle();
    checkOutput("dz_enable_count", enableCount, 0);
    checkOutput("dz_idle", resp_valid, 0);

    // Backpressure: response held for five cycles while both requesters wait
    resp_ready = 1'b0;
    applyStimulus(1, 16'd3, 16'hFFFC, 3'd2, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(1, 16'd1, 16'd1, 3'd0, 1, 16'd1, 16'd1, 3'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d_valid", i), resp_valid, 1);
      checkOutput($sformatf("bp%0d_data", i), resp_data, 16'hFFF4);
      checkOutput($sformatf("bp%0d_sign", i), resp_sign, 1);
      checkOutput($sformatf("bp%0d_readies", i), {req0_ready, req1_ready}, 0);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    resp_ready = 1'b1;
    stepCycle();
    resp_ready = 1'b0;
    checkOutput("bp_release", resp_valid, 0);
    resp_ready = 1'b1;

    // Illegal op from req0, then priority must favour req1
    applyStimulus(1, 16'd4, 16'd4, 3'd7, 0, 0, 0, 0);
    checkOutput("bad_ready0", req0_ready, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bad_valid", resp_valid, 1);
    checkOutput("bad_err", resp_err, 1);
    checkOutput("bad_data", resp_data, 0);
    stepCycle();
    applyStimulus(1, 16'd1, 16'd1, 3'd0, 1, 16'd1, 16'd1, 3'd0);
    checkOutput("bad_prio_ready1", req1_ready, 1);
    checkOutput("bad_prio_ready0", req0_ready, 0);

    // Reset in the middle of EXEC discards the operation
    applyStimulus(0, 0, 0, 0, 1, 16'd8, 16'd8, 3'd0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rx_exec_enable", alu_enable, 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rx_enable", alu_enable, 0);
    checkOutput("rx_tmp1", alu_tmp1, 0);
    checkOutput("rx_resp_id", resp_id, 0);
    checkOutput("rx_valid", resp_valid, 0);
    stepCycle();
    reset = 1'b0;
    respSeen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      respSeen = respSeen | resp_valid;
    end
    checkOutput("rx_no_resp", respSeen, 0);
    applyStimulus(1, 16'd1, 16'd1, 3'd0, 1, 16'd1, 16'd1, 3'd0);
    checkOutput("rx_grant0", req0_ready, 1);
    checkOutput("rx_grant1", req1_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
